// File: rtl/tg_seq_engine.sv
// Table-driven TG sequencer: runs a loadable list of write/read/poll/delay commands
// through the one-pulse request interface of tg_axi_master and reports done/error/capture.
module tg_seq_engine #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int CMD_DEPTH      = 16,
  parameter int POLL_WAIT      = 5000,
  parameter int POLL_MAX       = 64,
  parameter int GAP_CYCLES     = 5,
  localparam int PCW = $clog2(CMD_DEPTH),
  localparam int SW  = AXI_DATA_WIDTH / 8,
  localparam int CW  = 3 + SW + AXI_ADDR_WIDTH + 2 * AXI_DATA_WIDTH
) (
  input  logic                      m_axi_aclk,
  input  logic                      m_axi_areset,
  input  logic                      cmd_we,
  input  logic [PCW-1:0]            cmd_waddr,
  input  logic [CW-1:0]             cmd_wdata,
  input  logic                      start,
  input  logic                      abort,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [1:0]                err_code,
  output logic [PCW-1:0]            err_pc,
  output logic                      cap_valid,
  output logic [AXI_DATA_WIDTH-1:0] cap_data,
  output logic [PCW-1:0]            cap_pc,
  output logic                      wr_req,
  output logic                      rd_req,
  output logic [AXI_ADDR_WIDTH-1:0] addr,
  output logic [AXI_DATA_WIDTH-1:0] wdata,
  output logic [SW-1:0]             wstrb,
  input  logic                      op_ack,
  input  logic [AXI_DATA_WIDTH-1:0] rdata
);

  localparam int CNTW = (AXI_DATA_WIDTH > 32) ? AXI_DATA_WIDTH : 32;
  localparam int TW   = $clog2(POLL_MAX + 1);

  localparam logic [2:0] OP_END   = 3'd0;
  localparam logic [2:0] OP_WRITE = 3'd1;
  localparam logic [2:0] OP_READ  = 3'd2;
  localparam logic [2:0] OP_POLL  = 3'd3;
  localparam logic [2:0] OP_DELAY = 3'd4;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_ILLEGAL = 2'd2;
  localparam logic [1:0] ERR_ABORT   = 2'd3;

  localparam logic [PCW-1:0] PC_LAST = PCW'(CMD_DEPTH - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT_ACK, S_GAP, S_PWAIT, S_DELAY, S_FINISH
  } state_t;

  state_t                    state_reg, state_next;
  logic [PCW-1:0]            pc_reg, pc_next;
  logic [CNTW-1:0]           cnt_reg, cnt_next;
  logic [TW-1:0]             tries_reg, tries_next;
  logic                      abort_pend_reg, abort_pend_next;
  logic                      error_reg, error_next;
  logic [1:0]                err_code_reg, err_code_next;
  logic [PCW-1:0]            err_pc_reg, err_pc_next;
  logic                      cap_valid_reg, cap_valid_next;
  logic [AXI_DATA_WIDTH-1:0] cap_data_reg, cap_data_next;
  logic [PCW-1:0]            cap_pc_reg, cap_pc_next;
  logic [AXI_ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [AXI_DATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic [SW-1:0]             wstrb_reg, wstrb_next;

  // Command table; the table is only writable in IDLE, so cmd_q tracks slot pc for the whole command.
  logic [CW-1:0] cmd_mem [CMD_DEPTH];
  logic [CW-1:0] cmd_q;

  always_ff @(posedge m_axi_aclk) begin
    if (cmd_we && state_reg == S_IDLE) cmd_mem[cmd_waddr] <= cmd_wdata;
    cmd_q <= cmd_mem[pc_reg];
  end

  logic [2:0]                cmd_op;
  logic [SW-1:0]             cmd_strb;
  logic [AXI_ADDR_WIDTH-1:0] cmd_addr;
  logic [AXI_DATA_WIDTH-1:0] cmd_data;
  logic [AXI_DATA_WIDTH-1:0] cmd_mask;

  assign cmd_op   = cmd_q[CW-1 -: 3];
  assign cmd_strb = cmd_q[2*AXI_DATA_WIDTH + AXI_ADDR_WIDTH +: SW];
  assign cmd_addr = cmd_q[2*AXI_DATA_WIDTH +: AXI_ADDR_WIDTH];
  assign cmd_data = cmd_q[AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
  assign cmd_mask = cmd_q[0 +: AXI_DATA_WIDTH];

  logic            poll_match;
  logic [CNTW-1:0] dly_last;
  logic            adv;
  logic            fail;
  logic [1:0]      fail_code;

  assign poll_match = ((rdata ^ cmd_data) & cmd_mask) == '0;
  assign dly_last   = CNTW'(cmd_data) - CNTW'(1);

  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      state_reg      <= S_IDLE;
      pc_reg         <= '0;
      cnt_reg        <= '0;
      tries_reg      <= '0;
      abort_pend_reg <= 1'b0;
      error_reg      <= 1'b0;
      err_code_reg   <= ERR_NONE;
      err_pc_reg     <= '0;
      cap_valid_reg  <= 1'b0;
      cap_data_reg   <= '0;
      cap_pc_reg     <= '0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      wstrb_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      cnt_reg        <= cnt_next;
      tries_reg      <= tries_next;
      abort_pend_reg <= abort_pend_next;
      error_reg      <= error_next;
      err_code_reg   <= err_code_next;
      err_pc_reg     <= err_pc_next;
      cap_valid_reg  <= cap_valid_next;
      cap_data_reg   <= cap_data_next;
      cap_pc_reg     <= cap_pc_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      wstrb_reg      <= wstrb_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    cnt_next        = cnt_reg;
    tries_next      = tries_reg;
    abort_pend_next = abort_pend_reg;
    error_next      = error_reg;
    err_code_next   = err_code_reg;
    err_pc_next     = err_pc_reg;
    cap_valid_next  = 1'b0;
    cap_data_next   = cap_data_reg;
    cap_pc_next     = cap_pc_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    wstrb_next      = wstrb_reg;
    adv             = 1'b0;
    fail            = 1'b0;
    fail_code       = ERR_NONE;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next      = S_FETCH;
          pc_next         = '0;
          error_next      = 1'b0;
          err_code_next   = ERR_NONE;
          err_pc_next     = '0;
          abort_pend_next = 1'b0;
        end
      end
      S_FETCH: begin
        if (abort) begin
          fail = 1'b1; fail_code = ERR_ABORT;
        end else begin
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        if (abort) begin
          fail = 1'b1; fail_code = ERR_ABORT;
        end else begin
          case (cmd_op)
            OP_END: state_next = S_FINISH;
            OP_WRITE, OP_READ, OP_POLL: begin
              addr_next  = cmd_addr;
              wdata_next = (cmd_op == OP_WRITE) ? cmd_data : '0;
              wstrb_next = (cmd_op == OP_WRITE) ? cmd_strb : '0;
              tries_next = '0;
              state_next = S_ISSUE;
            end
            OP_DELAY: begin
              if (cmd_data == '0) begin
                adv = 1'b1;
              end else begin
                cnt_next   = '0;
                state_next = S_DELAY;
              end
            end
            default: begin
              fail = 1'b1; fail_code = ERR_ILLEGAL;
            end
          endcase
        end
      end
      // Once a request is out the transaction must finish, so abort is only remembered here.
      S_ISSUE: begin
        if (abort) abort_pend_next = 1'b1;
        state_next = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (abort) abort_pend_next = 1'b1;
        if (op_ack) begin
          if (cmd_op == OP_READ || cmd_op == OP_POLL) begin
            cap_valid_next = 1'b1;
            cap_data_next  = rdata;
            cap_pc_next    = pc_reg;
          end
          if (abort || abort_pend_reg) begin
            fail = 1'b1; fail_code = ERR_ABORT;
          end else if (cmd_op == OP_POLL && !poll_match) begin
            if (tries_reg == TW'(POLL_MAX - 1)) begin
              fail = 1'b1; fail_code = ERR_TIMEOUT;
            end else begin
              tries_next = tries_reg + TW'(1);
              cnt_next   = '0;
              state_next = (POLL_WAIT == 0) ? S_ISSUE : S_PWAIT;
            end
          end else if (GAP_CYCLES == 0) begin
            adv = 1'b1;
          end else begin
            cnt_next   = '0;
            state_next = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (abort) begin
          fail = 1'b1; fail_code = ERR_ABORT;
        end else if (cnt_reg == CNTW'(GAP_CYCLES - 1)) begin
          adv = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNTW'(1);
        end
      end
      S_PWAIT: begin
        if (abort) begin
          fail = 1'b1; fail_code = ERR_ABORT;
        end else if (cnt_reg == CNTW'(POLL_WAIT - 1)) begin
          state_next = S_ISSUE;
        end else begin
          cnt_next = cnt_reg + CNTW'(1);
        end
      end
      S_DELAY: begin
        if (abort) begin
          fail = 1'b1; fail_code = ERR_ABORT;
        end else if (cnt_reg == dly_last) begin
          adv = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNTW'(1);
        end
      end
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase

    // Running off the last slot ends the run normally; pc never wraps back to 0.
    if (adv) begin
      if (pc_reg == PC_LAST) begin
        state_next = S_FINISH;
      end else begin
        pc_next    = pc_reg + PCW'(1);
        state_next = S_FETCH;
      end
    end
    if (fail) begin
      error_next    = 1'b1;
      err_code_next = fail_code;
      err_pc_next   = pc_reg;
      state_next    = S_FINISH;
    end
  end

  assign busy      = (state_reg != S_IDLE) && (state_reg != S_FINISH);
  assign done      = (state_reg == S_FINISH);
  assign wr_req    = (state_reg == S_ISSUE) && (cmd_op == OP_WRITE);
  assign rd_req    = (state_reg == S_ISSUE) && (cmd_op == OP_READ || cmd_op == OP_POLL);
  assign error     = error_reg;
  assign err_code  = err_code_reg;
  assign err_pc    = err_pc_reg;
  assign cap_valid = cap_valid_reg;
  assign cap_data  = cap_data_reg;
  assign cap_pc    = cap_pc_reg;
  assign addr      = addr_reg;
  assign wdata     = wdata_reg;
  assign wstrb     = wstrb_reg;

endmodule

// File: tb/tb_tg_seq_engine.sv
// Directed bench for tg_seq_engine: a table of command programs with expected results,
// plus hand-written sequences for abort, delay timing and reset mid-run.
module tb_tg_seq_engine;
  localparam int AW = 32, DW = 32, SW = 4, DEPTH = 16, PCW = 4;
  localparam int PW = 5000, PM = 4, GAP = 5;
  localparam int CW = 3 + SW + AW + 2 * DW;

  localparam logic [2:0] OP_END = 3'd0, OP_WRITE = 3'd1, OP_READ = 3'd2;
  localparam logic [2:0] OP_POLL = 3'd3, OP_DELAY = 3'd4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           cmd_we = 1'b0;
  logic [PCW-1:0] cmd_waddr = '0;
  logic [CW-1:0]  cmd_wdata = '0;
  logic           start = 1'b0, abort = 1'b0;
  logic           busy, done, error, cap_valid, wr_req, rd_req;
  logic [1:0]     err_code;
  logic [PCW-1:0] err_pc, cap_pc;
  logic [DW-1:0]  cap_data, wdata;
  logic [AW-1:0]  addr;
  logic [SW-1:0]  wstrb;
  logic           op_ack = 1'b0;
  logic [DW-1:0]  rdata = '0;

  tg_seq_engine #(
    .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .CMD_DEPTH(DEPTH),
    .POLL_WAIT(PW), .POLL_MAX(PM), .GAP_CYCLES(GAP)
  ) dut (
    .m_axi_aclk(clk), .m_axi_areset(rst),
    .cmd_we(cmd_we), .cmd_waddr(cmd_waddr), .cmd_wdata(cmd_wdata),
    .start(start), .abort(abort),
    .busy(busy), .done(done), .error(error), .err_code(err_code), .err_pc(err_pc),
    .cap_valid(cap_valid), .cap_data(cap_data), .cap_pc(cap_pc),
    .wr_req(wr_req), .rd_req(rd_req), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .op_ack(op_ack), .rdata(rdata)
  );

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: counts and timestamps of DUT pulses, sampled mid-cycle.
  int wr_cnt = 0, rd_cnt = 0, cap_cnt = 0, done_cnt = 0;
  int wr_t [64];
  int rd_t [64];
  logic [DW-1:0]  last_cap_data = '0;
  logic [PCW-1:0] last_cap_pc = '0;
  always @(negedge clk) begin
    if (wr_req) begin
      if (wr_cnt < 64) wr_t[wr_cnt] = cyc;
      wr_cnt++;
    end
    if (rd_req) begin
      if (rd_cnt < 64) rd_t[rd_cnt] = cyc;
      rd_cnt++;
    end
    if (cap_valid) begin
      cap_cnt++;
      last_cap_data = cap_data;
      last_cap_pc   = cap_pc;
    end
    if (done) done_cnt++;
  end

  // Bus model standing in for tg_axi_master: op_ack ack_delay+1 cycles after the request.
  int ack_delay = 2;
  int poll_at = 1000;
  int rd0_base = 0;
  int rd0_cnt = 0, ack_cnt = 0, hold_err = 0, rd_nz_err = 0;
  int ack_t [64];
  logic pend = 1'b0, p_rd = 1'b0;
  int dly_cnt = 0;
  logic [AW-1:0] p_addr = '0;
  logic [DW-1:0] p_wdata = '0;
  logic [SW-1:0] p_wstrb = '0;
  logic [AW+DW+SW-1:0] last_wr = '0;
  always @(negedge clk) begin
    if (rst) begin
      op_ack = 1'b0;
      pend   = 1'b0;
    end else begin
      op_ack = 1'b0;
      if (pend) begin
        if (addr !== p_addr || wdata !== p_wdata || wstrb !== p_wstrb) hold_err++;
        if (dly_cnt == 0) begin
          op_ack = 1'b1;
          pend   = 1'b0;
          if (ack_cnt < 64) ack_t[ack_cnt] = cyc;
          ack_cnt++;
          if (!p_rd) rdata = '0;
          else if (p_addr == 32'h0) begin
            rd0_cnt++;
            rdata = (rd0_cnt - rd0_base >= poll_at) ? 32'h4000_0042 : 32'h0000_0042;
          end else if (p_addr == 32'h0C) rdata = 32'hDEAD_BEEF;
          else rdata = '0;
        end else begin
          dly_cnt--;
        end
      end
      if (wr_req || rd_req) begin
        pend    = 1'b1;
        p_rd    = rd_req;
        p_addr  = addr;
        p_wdata = wdata;
        p_wstrb = wstrb;
        dly_cnt = ack_delay;
        if (rd_req && (wdata != '0 || wstrb != '0)) rd_nz_err++;
        if (wr_req) last_wr = {addr, wdata, wstrb};
      end
    end
  end

  function automatic logic [CW-1:0] mk(input logic [2:0] op, input logic [3:0] st,
      input logic [31:0] a, input logic [31:0] d, input logic [31:0] m);
    return {op, st, a, d, m};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    string          name;
    int             poll_at;
    int             exp_wr;
    int             exp_rd;
    int             exp_cap;
    logic           exp_err;
    logic [1:0]     exp_code;
    logic [PCW-1:0] exp_pc;
    logic [DW-1:0]  exp_cdata;
    logic [PCW-1:0] exp_cpc;
    int             exp_space;
  } vec_t;

  vec_t          vecs [5];
  logic [CW-1:0] prog [8][5];
  logic [CW-1:0] filler [8];
  int            st_cyc = 0;

  task automatic load(input int p);
    for (int s = 0; s < DEPTH; s++) begin
      cmd_we    = 1'b1;
      cmd_waddr = PCW'(s);
      cmd_wdata = (s < 5) ? prog[p][s] : filler[p];
      tick();
    end
    cmd_we = 1'b0;
  endtask

  task automatic wait_done(input int db, input int budget);
    int n;
    n = 0;
    while (done_cnt == db && n < budget) begin
      tick();
      n++;
    end
    if (done_cnt == db) begin
      checks++;
      $display("FAIL run_timeout: done not seen within %0d cycles", budget);
      rst = 1'b1;
      tick();
      rst = 1'b0;
    end
    repeat (10) tick();
  endtask

  task automatic run_prog(input int budget);
    int db;
    db = done_cnt;
    start  = 1'b1;
    st_cyc = cyc;
    tick();
    start = 1'b0;
    wait_done(db, budget);
  endtask

  initial begin
    int wb, rb, cb, db, ab, lat, n;

    for (int p = 0; p < 8; p++) begin
      filler[p] = '0;
      for (int s = 0; s < 5; s++) prog[p][s] = '0;
    end
    prog[0][0] = mk(OP_WRITE, 4'hF, 32'h04, 32'h1, 32'h0);
    prog[0][1] = mk(OP_WRITE, 4'hF, 32'h08, 32'hAA, 32'h0);
    prog[0][2] = mk(OP_WRITE, 4'hF, 32'h00, 32'h42, 32'h0);
    prog[0][3] = mk(OP_POLL, 4'h0, 32'h00, 32'h4000_0000, 32'h4000_0000);
    prog[1][0] = mk(OP_POLL, 4'h0, 32'h10, 32'h55, 32'hFF);
    prog[2][0] = mk(OP_READ, 4'h0, 32'h0C, 32'h0, 32'h0);
    prog[3][0] = mk(OP_WRITE, 4'hF, 32'h20, 32'h5, 32'h0);
    prog[3][1] = mk(3'd6, 4'hF, 32'h24, 32'h6, 32'h0);
    prog[4][0] = mk(OP_WRITE, 4'h1, 32'h30, 32'h7, 32'h0);
    filler[4]  = mk(OP_DELAY, 4'h0, 32'h0, 32'h0, 32'h0);
    prog[5][0] = mk(OP_WRITE, 4'h3, 32'h40, 32'h9, 32'h0);
    prog[5][1] = mk(OP_WRITE, 4'hF, 32'h44, 32'hA, 32'h0);
    prog[6][0] = mk(OP_WRITE, 4'hF, 32'h50, 32'h1, 32'h0);
    prog[6][1] = mk(OP_DELAY, 4'h0, 32'h0, 32'd100, 32'h0);
    prog[6][2] = mk(OP_WRITE, 4'hF, 32'h54, 32'h2, 32'h0);
    prog[7][0] = mk(OP_WRITE, 4'hF, 32'h60, 32'h3, 32'h0);
    prog[7][1] = mk(OP_DELAY, 4'h0, 32'h0, 32'd1000, 32'h0);

    // Poll spacing: op_ack 3 cycles after rd_req, then POLL_WAIT idle cycles, then ISSUE.
    vecs[0] = '{"wr_poll", 3, 3, 3, 3, 1'b0, 2'd0, 4'd0, 32'h4000_0042, 4'd3, PW + 4};
    vecs[1] = '{"poll_tmo", 1000, 0, 4, 4, 1'b1, 2'd1, 4'd0, 32'h0, 4'd0, PW + 4};
    vecs[2] = '{"read", 1000, 0, 1, 1, 1'b0, 2'd0, 4'd0, 32'hDEAD_BEEF, 4'd0, 0};
    vecs[3] = '{"illegal", 1000, 1, 0, 0, 1'b1, 2'd2, 4'd1, 32'h0, 4'd0, 0};
    vecs[4] = '{"no_end", 1000, 1, 0, 0, 1'b0, 2'd0, 4'd0, 32'h0, 4'd0, 0};

    repeat (3) tick();
    chk("rst_outputs", 128'(|{busy, done, error, err_code, err_pc, cap_valid, cap_data, cap_pc,
                             wr_req, rd_req, addr, wdata, wstrb}), 128'd0);
    rst = 1'b0;
    tick();
    chk("idle_after_rst", 128'({busy, done, wr_req, rd_req}), 128'd0);

    for (int i = 0; i < 5; i++) begin
      load(i);
      poll_at  = vecs[i].poll_at;
      rd0_base = rd0_cnt;
      wb = wr_cnt; rb = rd_cnt; cb = cap_cnt; db = done_cnt;
      run_prog(30000);
      chk({vecs[i].name, "_wr"},   128'(wr_cnt - wb), 128'(vecs[i].exp_wr));
      chk({vecs[i].name, "_rd"},   128'(rd_cnt - rb), 128'(vecs[i].exp_rd));
      chk({vecs[i].name, "_cap"},  128'(cap_cnt - cb), 128'(vecs[i].exp_cap));
      chk({vecs[i].name, "_done"}, 128'(done_cnt - db), 128'd1);
      chk({vecs[i].name, "_err"},  128'({error, err_code, err_pc}),
          128'({vecs[i].exp_err, vecs[i].exp_code, vecs[i].exp_pc}));
      chk({vecs[i].name, "_busy"}, 128'(busy), 128'd0);
      if (vecs[i].exp_wr + vecs[i].exp_rd > 0) begin
        lat = ((wr_cnt > wb) && (rd_cnt == rb || wr_t[wb] < rd_t[rb])) ? wr_t[wb] : rd_t[rb];
        chk({vecs[i].name, "_latency"}, 128'(lat - st_cyc), 128'd3);
      end
      if (vecs[i].exp_cap > 0)
        chk({vecs[i].name, "_capture"}, 128'({last_cap_data, last_cap_pc}),
            128'({vecs[i].exp_cdata, vecs[i].exp_cpc}));
      if (vecs[i].exp_space > 0)
        for (int j = 0; j < vecs[i].exp_rd - 1; j++)
          chk({vecs[i].name, "_spacing"}, 128'(rd_t[rb + j + 1] - rd_t[rb + j]),
              128'(vecs[i].exp_space));
      if (i == 0) chk("wr_poll_last_write", 128'(last_wr), 128'({32'h0, 32'h42, 4'hF}));
    end

    // Abort while a write awaits op_ack; start and cmd_we during the run must be dropped.
    load(5);
    ack_delay = 20;
    wb = wr_cnt; ab = ack_cnt; db = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (wr_cnt == wb && n < 100) begin
      tick();
      n++;
    end
    tick();
    abort = 1'b1; start = 1'b1; cmd_we = 1'b1; cmd_waddr = '0;
    cmd_wdata = mk(OP_READ, 4'h0, 32'h0C, 32'h0, 32'h0);
    tick();
    abort = 1'b0; start = 1'b0; cmd_we = 1'b0;
    wait_done(db, 500);
    chk("abort_wr", 128'(wr_cnt - wb), 128'd1);
    chk("abort_ack", 128'(ack_cnt - ab), 128'd1);
    chk("abort_done", 128'(done_cnt - db), 128'd1);
    chk("abort_err", 128'({error, err_code, err_pc}), 128'({1'b1, 2'd3, 4'd0}));

    ack_delay = 2;
    wb = wr_cnt; rb = rd_cnt;
    run_prog(500);
    chk("rerun_wr", 128'(wr_cnt - wb), 128'd2);
    chk("rerun_rd", 128'(rd_cnt - rb), 128'd0);
    chk("rerun_err", 128'({error, err_code}), 128'd0);
    chk("rerun_last_write", 128'(last_wr), 128'({32'h44, 32'hA, 4'hF}));

    // Second wr_req = ack + GAP + (FETCH,DECODE) + 100 DELAY + (FETCH,DECODE) + 1 to ISSUE.
    load(6);
    wb = wr_cnt; ab = ack_cnt;
    run_prog(1000);
    chk("delay_wr", 128'(wr_cnt - wb), 128'd2);
    chk("delay_timing", 128'(wr_t[wb + 1] - ack_t[ab]), 128'(100 + GAP + 5));

    // Reset in the middle of a long DELAY.
    load(7);
    ab = ack_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (ack_cnt == ab && n < 100) begin
      tick();
      n++;
    end
    repeat (40) tick();
    chk("mid_delay_busy", 128'(busy), 128'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_outputs", 128'(|{busy, done, error, err_code, err_pc, cap_valid, cap_data, cap_pc,
                                 wr_req, rd_req, addr, wdata, wstrb}), 128'd0);
    rst = 1'b0;
    repeat (3) tick();
    chk("mid_rst_idle", 128'(busy), 128'd0);
    wb = wr_cnt; db = done_cnt;
    run_prog(3000);
    chk("table_kept_wr", 128'(wr_cnt - wb), 128'd1);
    chk("table_kept_done", 128'(done_cnt - db), 128'd1);

    chk("hold_stable", 128'(hold_err), 128'd0);
    chk("read_wdata_zero", 128'(rd_nz_err), 128'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
